// File: rtl/wave_pdm_gen.sv
// -----------------------------------------------------------------------------
// wave_pdm_gen
//
// Multi-mode waveform generator with a first-order sigma-delta (PDM) output.
// A prescaled phase accumulator drives one of four waveforms: sawtooth,
// triangle, square or reverse sawtooth. The resulting PCM sample is modulated
// into a 1-bit density stream that is meant to drive a single pin through an
// off-chip RC filter.
//
// Parameters
//   WIDTH      PCM / phase / PDM error width in bits (>= 4)
//   STEP_BITS  width of the step input
//   INC_SHIFT  phase increment = step << INC_SHIFT (INC_SHIFT+STEP_BITS <= WIDTH)
//   PRESCALE   clk cycles per sample tick (>= 1)
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   enable       in   1 = advance prescaler and phase, 0 = freeze them
//   step         in   phase increment per sample tick (0 = hold phase)
//   mode         in   00 saw, 01 triangle, 10 square, 11 reverse saw
//   pcm_out      out  registered waveform sample (lags phase by one cycle)
//   sample_tick  out  registered 1-cycle pulse, high after each phase update
//   pdm_out      out  registered PDM bit stream
// -----------------------------------------------------------------------------
module wave_pdm_gen #(
  parameter int WIDTH     = 16,
  parameter int STEP_BITS = 4,
  parameter int INC_SHIFT = 8,
  parameter int PRESCALE  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [STEP_BITS-1:0] step,
  input  logic [1:0]           mode,
  output logic [WIDTH-1:0]     pcm_out,
  output logic                 sample_tick,
  output logic                 pdm_out
);

  typedef enum logic [1:0] {
    MODE_SAW     = 2'b00,
    MODE_TRI     = 2'b01,
    MODE_SQUARE  = 2'b10,
    MODE_REV_SAW = 2'b11
  } mode_e;

  // A one-cycle prescaler still needs a 1-bit counter to keep the types legal;
  // it simply stays at zero, so every enabled cycle is a tick.
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] pcm_q,   pcm_d;
  logic [WIDTH-1:0] err_q,   err_d;
  logic             tick_q,  tick_d;
  logic             pdm_q,   pdm_d;

  logic [WIDTH-1:0] phase_inc;
  logic [WIDTH-1:0] tri_lin;
  logic [WIDTH:0]   pdm_sum;
  mode_e            mode_sel;

  assign mode_sel  = mode_e'(mode);
  assign phase_inc = WIDTH'(step) << INC_SHIFT;

  // ---------------------------------------------------------------------------
  // Prescaler and phase accumulator
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    cnt_d   = cnt_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        // Modulo-2^WIDTH wrap is intentional: the phase is a circle.
        phase_d = phase_q + phase_inc;
        tick_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Waveform shaping (from the current phase, registered into pcm_q)
  // ---------------------------------------------------------------------------
  // Phase with its MSB dropped and doubled: ramps twice per period, mirrored on
  // the second half to form the triangle.
  assign tri_lin = {phase_q[WIDTH-2:0], 1'b0};

  always_comb begin
    pcm_d = '0;
    unique case (mode_sel)
      MODE_SAW:     pcm_d = phase_q;
      MODE_TRI:     pcm_d = phase_q[WIDTH-1] ? ~tri_lin : tri_lin;
      MODE_SQUARE:  pcm_d = phase_q[WIDTH-1] ? '1 : '0;
      MODE_REV_SAW: pcm_d = ~phase_q;
      default:      pcm_d = phase_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // First-order sigma-delta: the carry out of the error accumulator is the bit.
  // Density of ones equals pcm/2^WIDTH; the error wraps and never saturates.
  // ---------------------------------------------------------------------------
  assign pdm_sum = {1'b0, err_q} + {1'b0, pcm_q};

  always_comb begin
    pdm_d = pdm_sum[WIDTH];
    err_d = pdm_sum[WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values
    // of the others, independent of statement order.
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= '0;
      pcm_q   <= '0;
      err_q   <= '0;
      tick_q  <= 1'b0;
      pdm_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pcm_q   <= pcm_d;
      err_q   <= err_d;
      tick_q  <= tick_d;
      pdm_q   <= pdm_d;
    end
  end

  assign pcm_out     = pcm_q;
  assign sample_tick = tick_q;
  assign pdm_out     = pdm_q;

endmodule
